if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage sitting directly downstream of the PC register and upstream of decode. It takes the current fetch PC and issues it on the SRAM-like instruction bus. It tracks up to 2 outstanding requests, flags misaligned fetch addresses as AdEL, and buffers returned instructions in order for decode. Branch/exception redirects flush all in-flight and buffered work.

Parameters:
DEPTH, 2, combined capacity of in-flight requests plus buffered instructions (in-flight + buffered <= DEPTH at all times).

Ports:
clk  input  1  system clock, all state updates on posedge.
resetn  input  1  synchronous active-low reset.
pc_valid  input  1  PC stage presents a fetch address.
pc  input  32  fetch address.
pc_ready  output  1  fetch address consumed this cycle; PC stage must hold pc while low.
flush  input  1  redirect (branch taken/exception); kills all in-flight and buffered entries.
inst_req  output  1  bus request; per-cycle, no hold requirement on the bus side.
inst_addr  output  32  request address (= pc).
inst_addr_ok  input  1  bus accepted request this cycle.
inst_data_ok  input  1  read data returned this cycle, in request order.
inst_rdata  input  32  returned instruction.
id_valid  output  1  decode entry valid.
id_pc  output  32  PC of the entry.
id_inst  output  32  instruction of the entry (0 when id_adel is set).
id_adel  output  1  address-error-on-fetch flag for the entry.
id_ready  input  1  decode consumes the head entry when id_valid & id_ready.

Behaviour:
- State: pending queue (DEPTH entries of {pc, discard}), output FIFO (DEPTH entries of {pc, inst, adel}), and occupancy counters.
- credit = (pending_cnt + buf_cnt + pop_this_cycle) < DEPTH, where pop_this_cycle = id_valid & id_ready.
- Aligned PC (pc[1:0] == 0):
  - inst_req = pc_valid & credit & ~flush.
  - inst_addr = pc, combinational.
  - On inst_req & inst_addr_ok: push {pc, discard=0} into the pending queue; pc_ready = 1.
- Misaligned PC (pc[1:0] != 0):
  - inst_req = 0.
  - Accepted only when pending queue is empty & credit & ~flush. On accept, push {pc, inst=0, adel=1} directly into the output FIFO; pc_ready = 1.
  - Otherwise pc_ready = 0.
- Response: inst_data_ok pops the pending head.
  - discard = 1: the response is dropped.
  - discard = 0: push {head.pc, inst_rdata, 0} into the output FIFO.
  - Credit rule guarantees FIFO space, so no backpressure exists on data_ok.
  - inst_data_ok with an empty pending queue is ignored.
- Output: id_* are driven from the FIFO head. Latency from inst_data_ok in cycle T to id_valid is T+1. Push and pop in the same cycle are allowed.
- Flush (highest priority):
  - Set discard on all pending entries, including any popped that cycle, whose data is dropped.
  - Clear the output FIFO; id_valid = 0 next cycle.
  - inst_req = 0 and pc_ready = 0 in the flush cycle.
  - pending_cnt is retained so late responses are absorbed and keep consuming credit.
- Reset (resetn low at posedge, including mid-transaction):
  - Both queues are emptied.
  - id_valid = 0, id_pc = 0, id_inst = 0, id_adel = 0.
  - Combinationally while resetn low: inst_req = 0, pc_ready = 0.
  - Responses to pre-reset requests are the bus's responsibility, since the bus is reset together with this block.
- Ordering: id entries appear in exactly the order their PCs were accepted.

Test Plan:
1. Reset, then pc=0xbfc00000 valid, addr_ok=1 same cycle, data_ok 2 cycles later with rdata=0x24080001, id_ready=1 -> id_valid=1 one cycle after data_ok with id_pc=0xbfc00000, id_inst=0x24080001, id_adel=0.
2. Back-to-back aligned PCs 0x100, 0x104, 0x108 with id_ready=0 -> two requests issued, third held (pc_ready=0, inst_req=0); after id_ready=1 pops one entry, 0x108 issues in that cycle.
3. Two outstanding requests (0x200, 0x204), flush asserted, then both data_ok arrive -> both responses dropped, id_valid stays 0; new pc=0x300 issues only once credit frees, and its data is the first id entry.
4. pc=0xbfc00002 with pending queue empty -> inst_req=0, pc_ready=1, next cycle id_valid=1, id_adel=1, id_pc=0xbfc00002, id_inst=0.
5. Misaligned pc=0x1001 while 0x1000 is outstanding -> pc_ready=0 until 0x1000's data returns; id order is 0x1000 then 0x1001(adel).
6. resetn low for one cycle while one request is outstanding and one entry is buffered -> next cycle id_valid=0, counters zero, inst_req resumes for new pc with full DEPTH credit.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: issues PCs on the instruction bus, tracks
// outstanding requests and buffers returned instructions for decode.
module if_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pc_valid,
  input  logic [31:0] pc,
  output logic        pc_ready,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel,
  input  logic        id_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  function automatic ptr_t nxt(input ptr_t p);
    if (int'(p) == DEPTH - 1) return '0;
    return p + ptr_t'(1);
  endfunction

  logic [31:0]      q_pc [DEPTH];
  logic [DEPTH-1:0] q_dis;
  ptr_t             q_hd, q_tl;
  cnt_t             q_cnt;

  logic [31:0]      f_pc   [DEPTH];
  logic [31:0]      f_inst [DEPTH];
  logic [DEPTH-1:0] f_adel;
  ptr_t             f_hd, f_tl;
  cnt_t             f_cnt;

  logic        aligned, pop, credit;
  logic        mis_acc, q_push, rsp, keep, f_push;
  logic [CW:0] occ, lim;
  logic [31:0] f_wpc, f_winst;

  // A decode pop this cycle frees a slot for a new fetch in the same cycle
  always_comb begin
    aligned  = (pc[1:0] == 2'b00);
    pop      = id_valid & id_ready;
    occ      = {1'b0, q_cnt} + {1'b0, f_cnt};
    lim      = (CW+1)'(DEPTH) + {{CW{1'b0}}, pop};
    credit   = occ < lim;
    inst_req = resetn & pc_valid & aligned & credit & ~flush;
    mis_acc  = resetn & pc_valid & ~aligned & (q_cnt == '0)
             & credit & ~flush;
    q_push   = inst_req & inst_addr_ok;
    pc_ready = q_push | mis_acc;
    rsp      = inst_data_ok & (q_cnt != '0);
    keep     = rsp & ~q_dis[q_hd] & ~flush;
    f_push   = keep | mis_acc;
    f_wpc    = keep ? q_pc[q_hd] : pc;
    f_winst  = keep ? inst_rdata : 32'h0;
  end

  assign inst_addr = pc;
  assign id_valid  = (f_cnt != '0);
  assign id_pc     = id_valid ? f_pc[f_hd]   : 32'h0;
  assign id_inst   = id_valid ? f_inst[f_hd] : 32'h0;
  assign id_adel   = id_valid & f_adel[f_hd];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q_hd  <= '0;
      q_tl  <= '0;
      q_cnt <= '0;
      q_dis <= '0;
      f_hd  <= '0;
      f_tl  <= '0;
      f_cnt <= '0;
    end else begin
      if (q_push) begin
        q_dis[q_tl] <= 1'b0;
        q_tl        <= nxt(q_tl);
      end
      if (rsp) q_hd <= nxt(q_hd);
      q_cnt <= q_cnt + cnt_t'(q_push) - cnt_t'(rsp);
      // Outstanding requests stay counted so late data is absorbed
      if (flush) q_dis <= '1;
      if (flush) begin
        f_hd  <= '0;
        f_tl  <= '0;
        f_cnt <= '0;
      end else begin
        if (f_push) f_tl <= nxt(f_tl);
        if (pop)    f_hd <= nxt(f_hd);
        f_cnt <= f_cnt + cnt_t'(f_push) - cnt_t'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (q_push) q_pc[q_tl] <= pc;
    if (f_push && !flush) begin
      f_pc[f_tl]   <= f_wpc;
      f_inst[f_tl] <= f_winst;
      f_adel[f_tl] <= ~keep;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a bus model and an in-order
// scoreboard of expected decode entries.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        resetn, pc_valid, flush;
  logic [31:0] pc, inst_rdata;
  logic        inst_addr_ok, inst_data_ok, id_ready;
  logic        pc_ready, inst_req, id_valid, id_adel;
  logic [31:0] inst_addr, id_pc, id_inst;

  if_stage #(.DEPTH(2)) dut (
    .clk(clk), .resetn(resetn),
    .pc_valid(pc_valid), .pc(pc), .pc_ready(pc_ready),
    .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_adel(id_adel), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] busq[$];
  int          n_run = 0;
  int          n_fail = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'hbfc00000) return 32'h24080001;
    return a ^ 32'h3c5a0000;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (resetn && !flush && id_valid && id_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(id_pc), 32'hffffffff);
      end else begin
        e = sb.pop_front();
        check("sb_pc", id_pc, e.pc);
        check("sb_inst", id_inst, e.inst);
        check("sb_adel", 32'(id_adel), 32'(e.adel));
      end
    end
    if (!resetn) begin
      sb.delete();
      busq.delete();
    end else if (flush) begin
      sb.delete();
    end
    if (resetn && pc_valid && pc_ready) begin
      e.pc   = pc;
      e.adel = (pc[1:0] != 2'b00);
      e.inst = e.adel ? 32'h0 : mem(pc);
      sb.push_back(e);
      if (!e.adel) busq.push_back(pc);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  task automatic rsp_on;
    inst_data_ok = 1'b1;
    inst_rdata   = (busq.size() > 0) ? mem(busq[0]) : 32'h0;
  endtask

  task automatic rsp_done;
    if (busq.size() > 0) void'(busq.pop_front());
    inst_data_ok = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; pc_valid = 1'b0; flush = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
    id_ready = 1'b0; pc = 32'hbfc00000; inst_rdata = 32'h0;
    tick; tick;
    pc_valid = 1'b1;
    neg;
    check("rst_req", 32'(inst_req), 0);
    check("rst_rdy", 32'(pc_ready), 0);
    check("rst_valid", 32'(id_valid), 0);
    check("rst_pc", id_pc, 0);
    tick;

    // 1: single aligned fetch
    resetn = 1'b1; inst_addr_ok = 1'b1; id_ready = 1'b1;
    neg;
    check("t1_req", 32'(inst_req), 1);
    check("t1_rdy", 32'(pc_ready), 1);
    check("t1_addr", inst_addr, 32'hbfc00000);
    tick;
    pc_valid = 1'b0; inst_addr_ok = 1'b0;
    neg; tick;
    rsp_on;
    neg;
    check("t1_lat", 32'(id_valid), 0);
    tick; rsp_done;
    neg;
    check("t1_valid", 32'(id_valid), 1);
    check("t1_pc", id_pc, 32'hbfc00000);
    check("t1_inst", id_inst, 32'h24080001);
    check("t1_adel", 32'(id_adel), 0);
    tick;
    neg;
    check("t1_empty", 32'(id_valid), 0);
    tick;

    // 2: credit limit with decode stalled
    id_ready = 1'b0; pc_valid = 1'b1; inst_addr_ok = 1'b1;
    pc = 32'h100;
    neg; check("t2_rdy0", 32'(pc_ready), 1); tick;
    pc = 32'h104;
    neg; check("t2_rdy1", 32'(pc_ready), 1); tick;
    pc = 32'h108;
    neg;
    check("t2_hold_req", 32'(inst_req), 0);
    check("t2_hold_rdy", 32'(pc_ready), 0);
    tick;
    rsp_on; neg; check("t2_hold_a", 32'(inst_req), 0); tick; rsp_done;
    rsp_on; neg; check("t2_hold_b", 32'(inst_req), 0); tick; rsp_done;
    neg;
    check("t2_hold_c", 32'(inst_req), 0);
    check("t2_buf", 32'(id_valid), 1);
    tick;
    id_ready = 1'b1;
    neg;
    check("t2_pop_req", 32'(inst_req), 1);
    check("t2_pop_rdy", 32'(pc_ready), 1);
    tick;
    pc_valid = 1'b0; inst_addr_ok = 1'b0;
    rsp_on; neg; tick; rsp_done;
    neg; tick; neg; tick;

    // 3: flush with two requests in flight
    pc_valid = 1'b1; inst_addr_ok = 1'b1;
    pc = 32'h200; neg; tick;
    pc = 32'h204; neg; tick;
    pc = 32'h300; flush = 1'b1;
    neg;
    check("t3_fl_req", 32'(inst_req), 0);
    check("t3_fl_rdy", 32'(pc_ready), 0);
    tick;
    flush = 1'b0;
    neg; check("t3_nocred", 32'(inst_req), 0); tick;
    rsp_on; neg; check("t3_nocred2", 32'(pc_ready), 0); tick; rsp_done;
    rsp_on;
    neg;
    check("t3_drop0", 32'(id_valid), 0);
    check("t3_issue", 32'(inst_req), 1);
    tick; rsp_done;
    pc_valid = 1'b0; inst_addr_ok = 1'b0;
    neg; check("t3_drop1", 32'(id_valid), 0); tick;
    rsp_on; neg; tick; rsp_done;
    neg;
    check("t3_valid", 32'(id_valid), 1);
    check("t3_pc", id_pc, 32'h300);
    tick;

    // 4: misaligned fetch with nothing pending
    pc_valid = 1'b1; pc = 32'hbfc00002;
    neg;
    check("t4_req", 32'(inst_req), 0);
    check("t4_rdy", 32'(pc_ready), 1);
    tick;
    pc_valid = 1'b0;
    neg;
    check("t4_valid", 32'(id_valid), 1);
    check("t4_adel", 32'(id_adel), 1);
    check("t4_pc", id_pc, 32'hbfc00002);
    check("t4_inst", id_inst, 32'h0);
    tick;

    // 5: misaligned waits behind an outstanding fetch
    pc_valid = 1'b1; inst_addr_ok = 1'b1; pc = 32'h1000;
    neg; tick;
    pc = 32'h1001;
    neg;
    check("t5_rdy0", 32'(pc_ready), 0);
    check("t5_req0", 32'(inst_req), 0);
    tick;
    rsp_on; neg; check("t5_rdy1", 32'(pc_ready), 0); tick; rsp_done;
    neg;
    check("t5_rdy2", 32'(pc_ready), 1);
    check("t5_pc0", id_pc, 32'h1000);
    tick;
    pc_valid = 1'b0; inst_addr_ok = 1'b0;
    neg;
    check("t5_pc1", id_pc, 32'h1001);
    check("t5_adel", 32'(id_adel), 1);
    tick;

    // 6: reset with one pending and one buffered entry
    id_ready = 1'b0; pc_valid = 1'b1; inst_addr_ok = 1'b1;
    pc = 32'h400; neg; tick;
    pc = 32'h404; neg; tick;
    pc_valid = 1'b0;
    rsp_on; neg; tick; rsp_done;
    resetn = 1'b0; pc_valid = 1'b1; pc = 32'h500;
    neg;
    check("t6_rst_req", 32'(inst_req), 0);
    check("t6_rst_rdy", 32'(pc_ready), 0);
    tick;
    resetn = 1'b1;
    neg;
    check("t6_valid", 32'(id_valid), 0);
    check("t6_req0", 32'(inst_req), 1);
    tick;
    pc = 32'h504;
    neg; check("t6_req1", 32'(inst_req), 1); tick;
    pc = 32'h508;
    neg; check("t6_full", 32'(inst_req), 0); tick;
    pc_valid = 1'b0; inst_addr_ok = 1'b0; id_ready = 1'b1;
    rsp_on; neg; tick; rsp_done;
    rsp_on; neg; tick; rsp_done;
    neg; tick; neg; tick; neg; tick;

    check("sb_drain", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
